urv_mem_arb: RTL and testbench
==============================

URV_MEM_ARB -- requirements
Module: urv_mem_arb

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, giving the number of requesting channels (legal range 2..8).
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the request address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the data width; MASK_W SHALL equal DATA_W/8.
REQ-004 The block SHALL have parameter BURST_W, default 4, giving the burst field width; burst value b means b+1 beats.
REQ-005 The block SHALL have parameter RR_EN, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with channel 0 highest.
REQ-006 Ports (name direction width meaning): clk in 1 clock; rstn in 1 asynchronous active-low reset.
REQ-007 ch_req_valid in NUM_CH, ch_req_ready out NUM_CH: per-channel request handshake.
REQ-008 ch_req_type in NUM_CH (0 read, 1 write), ch_req_addr in NUM_CH*ADDR_W, ch_req_mask in NUM_CH*MASK_W, ch_req_data in NUM_CH*DATA_W, ch_req_burst in NUM_CH*BURST_W: packed per-channel request payload, channel i in slice i.
REQ-009 ch_resp_valid out NUM_CH, ch_resp_ready in NUM_CH: per-channel response handshake.
REQ-010 ch_resp_type out 1, ch_resp_data out DATA_W, ch_resp_last out 1: response payload, broadcast to all channels.
REQ-011 mem_req_valid out 1, mem_req_ready in 1, and mem_req_type/addr/mask/data/burst out (widths 1/ADDR_W/MASK_W/DATA_W/BURST_W): downstream request.
REQ-012 mem_resp_valid in 1, mem_resp_ready out 1, and mem_resp_type/data/last in (widths 1/DATA_W/1): downstream response.
REQ-013 busy out 1 (state not IDLE); grant_id out $clog2(NUM_CH) (registered granted channel).

Function
REQ-014 The FSM SHALL have states IDLE, XFER and RESP.
REQ-015 IDLE: when any ch_req_valid is high, the winner SHALL be registered into grant_id and the FSM SHALL move to XFER on the next edge; ch_req_ready SHALL be all zero in IDLE.
REQ-016 The winner SHALL be the first valid channel scanning upward from the priority pointer with wrap; the pointer SHALL be fixed at 0 when RR_EN=0.
REQ-017 XFER: the granted channel's request SHALL drive mem_req_* combinationally; mem_req_valid SHALL equal ch_req_valid[grant_id]; only ch_req_ready[grant_id] SHALL equal mem_req_ready, all others 0.
REQ-018 Read: after one accepted request beat the FSM SHALL move to RESP.
REQ-019 Write: a BURST_W-bit beat counter SHALL load the first beat's burst field; the FSM SHALL move to RESP after burst+1 accepted beats; burst fields of later beats are ignored.
REQ-020 RESP: ch_resp_valid[grant_id] SHALL equal mem_resp_valid, mem_resp_ready SHALL equal ch_resp_ready[grant_id], response payload SHALL pass through combinationally.
REQ-021 mem_resp_ready and all ch_resp_valid SHALL be 0 outside RESP; early downstream responses are stalled, never dropped.
REQ-022 The FSM SHALL leave RESP on an accepted response beat with mem_resp_last=1, return to IDLE, and, if RR_EN=1, set the pointer to (grant_id+1) mod NUM_CH.
REQ-023 Only one transaction SHALL be outstanding; request-to-mem latency SHALL be exactly one cycle (valid in IDLE at edge t, mem_req_valid at t+1).
REQ-024 Requesters SHALL hold valid and payload until ready; the block does not check this, and deassertion in XFER simply stalls.
REQ-025 mem_resp_type SHALL pass through unchecked.

Reset
REQ-026 While rstn is low: state IDLE, grant_id 0, priority pointer 0, beat counter 0, busy 0, all valid/ready outputs 0.
REQ-027 Reset asserted mid-transaction SHALL abort it immediately with no further handshakes; after release, arbitration SHALL restart from pointer 0.

Verification
REQ-028 Read: ch1 read addr 0x100 burst 3, ch0 idle -> grant_id=1, one mem_req beat, four responses to ch1 only, last on the 4th; busy falls the next cycle.
REQ-029 Write: ch0 write burst 2 with mem_req_ready toggling -> exactly 3 beats forwarded in order, data/mask intact, FSM enters RESP only after the 3rd handshake.
REQ-030 RR fairness: NUM_CH=4, all channels continuously requesting single reads -> grant order 0,1,2,3,0; with RR_EN=0 -> always 0.
REQ-031 Early response: mem_resp_valid high during XFER -> mem_resp_ready stays 0 until RESP; no beat lost.
REQ-032 Reset mid-RESP: rstn low after 2 of 4 read beats -> all outputs 0 asynchronously; after release, a new ch2 request is granted with pointer 0.
REQ-033 Back-pressure: ch_resp_ready[grant_id]=0 for 5 cycles -> mem_resp_ready=0 and payload held; beat delivered once ready rises.

Source files
------------

// File: rtl/urv_mem_arb.sv
// Multi-channel memory request arbiter: grants one channel at a time, forwards its
// request burst downstream and routes the downstream response back to that channel.
module urv_mem_arb #(
    parameter  int NUM_CH  = 2,
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int BURST_W = 4,
    parameter  int RR_EN   = 1,
    parameter  int MASK_W  = DATA_W / 8,
    localparam int ID_W    = $clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_CH-1:0]         ch_req_valid,
    output logic [NUM_CH-1:0]         ch_req_ready,
    input  logic [NUM_CH-1:0]         ch_req_type,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_req_addr,
    input  logic [NUM_CH*MASK_W-1:0]  ch_req_mask,
    input  logic [NUM_CH*DATA_W-1:0]  ch_req_data,
    input  logic [NUM_CH*BURST_W-1:0] ch_req_burst,
    output logic [NUM_CH-1:0]         ch_resp_valid,
    input  logic [NUM_CH-1:0]         ch_resp_ready,
    output logic                      ch_resp_type,
    output logic [DATA_W-1:0]         ch_resp_data,
    output logic                      ch_resp_last,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_type,
    output logic [ADDR_W-1:0]         mem_req_addr,
    output logic [MASK_W-1:0]         mem_req_mask,
    output logic [DATA_W-1:0]         mem_req_data,
    output logic [BURST_W-1:0]        mem_req_burst,
    input  logic                      mem_resp_valid,
    output logic                      mem_resp_ready,
    input  logic                      mem_resp_type,
    input  logic [DATA_W-1:0]         mem_resp_data,
    input  logic                      mem_resp_last,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t               state;
    logic [ID_W-1:0]      ptr;
    logic [BURST_W-1:0]   beat_cnt;
    logic                 first_beat;
    logic [ID_W-1:0]      win, win_hi, win_lo;
    logic                 hit_hi;
    logic [NUM_CH-1:0]    sel;
    logic                 accept, resp_done;

    // Round-robin pick: lowest valid channel at or above ptr, else lowest valid overall.
    always_comb begin
        win_hi = '0;
        win_lo = '0;
        hit_hi = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_req_valid[i]) begin
                win_lo = ID_W'(i);
                if (ID_W'(i) >= ptr) begin
                    win_hi = ID_W'(i);
                    hit_hi = 1'b1;
                end
            end
        end
        win = hit_hi ? win_hi : win_lo;
    end

    always_comb begin
        sel           = '0;
        mem_req_type  = 1'b0;
        mem_req_addr  = '0;
        mem_req_mask  = '0;
        mem_req_data  = '0;
        mem_req_burst = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel[i]        = 1'b1;
                mem_req_type  = ch_req_type[i];
                mem_req_addr  = ch_req_addr[i*ADDR_W +: ADDR_W];
                mem_req_mask  = ch_req_mask[i*MASK_W +: MASK_W];
                mem_req_data  = ch_req_data[i*DATA_W +: DATA_W];
                mem_req_burst = ch_req_burst[i*BURST_W +: BURST_W];
            end
        end
    end

    assign busy           = (state != IDLE);
    assign mem_req_valid  = (state == XFER) && |(ch_req_valid & sel);
    assign ch_req_ready   = (state == XFER && mem_req_ready) ? sel : '0;
    assign ch_resp_valid  = (state == RESP && mem_resp_valid) ? sel : '0;
    assign mem_resp_ready = (state == RESP) && |(ch_resp_ready & sel);
    assign ch_resp_type   = mem_resp_type;
    assign ch_resp_data   = mem_resp_data;
    assign ch_resp_last   = mem_resp_last;

    assign accept    = mem_req_valid && mem_req_ready;
    assign resp_done = mem_resp_valid && mem_resp_ready && mem_resp_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            grant_id   <= '0;
            ptr        <= '0;
            beat_cnt   <= '0;
            first_beat <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|ch_req_valid) begin
                    grant_id   <= win;
                    first_beat <= 1'b1;
                    state      <= XFER;
                end
                XFER: if (accept) begin
                    first_beat <= 1'b0;
                    // The first beat decides type and length; later burst fields are ignored.
                    if (first_beat) begin
                        beat_cnt <= mem_req_burst;
                        if (!mem_req_type || mem_req_burst == '0)
                            state <= RESP;
                    end else begin
                        beat_cnt <= beat_cnt - BURST_W'(1);
                        if (beat_cnt == BURST_W'(1))
                            state <= RESP;
                    end
                end
                RESP: if (resp_done) begin
                    state <= IDLE;
                    if (RR_EN != 0)
                        ptr <= (grant_id == ID_W'(NUM_CH - 1)) ? '0 : grant_id + ID_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_urv_mem_arb.sv
// Bench for urv_mem_arb: transaction-level model checked every cycle plus directed scenarios.
module tb_urv_mem_arb;
    localparam int N = 4, AW = 32, DW = 32, BW = 4, MW = 4;

    logic clk = 1'b0, rstn = 1'b0;
    logic [N-1:0] ch_req_valid = '0, ch_req_type = '0, ch_resp_ready = '1;
    logic [N*AW-1:0] ch_req_addr = '0;
    logic [N*MW-1:0] ch_req_mask = '0;
    logic [N*DW-1:0] ch_req_data = '0;
    logic [N*BW-1:0] ch_req_burst = '0;
    logic mem_req_ready = 1'b0, mem_resp_valid = 1'b0, mem_resp_type = 1'b0, mem_resp_last = 1'b0;
    logic [DW-1:0] mem_resp_data = '0;

    logic [N-1:0] ch_req_ready, ch_resp_valid;
    logic ch_resp_type, ch_resp_last, mem_req_valid, mem_req_type, mem_resp_ready, busy;
    logic [DW-1:0] ch_resp_data, mem_req_data;
    logic [AW-1:0] mem_req_addr;
    logic [MW-1:0] mem_req_mask;
    logic [BW-1:0] mem_req_burst;
    logic [1:0] grant_id;

    logic [N-1:0] d1_ch_req_ready, d1_ch_resp_valid;
    logic d1_ch_resp_type, d1_ch_resp_last, d1_mem_req_valid, d1_mem_req_type, d1_mem_resp_ready, d1_busy;
    logic [DW-1:0] d1_ch_resp_data, d1_mem_req_data;
    logic [AW-1:0] d1_mem_req_addr;
    logic [MW-1:0] d1_mem_req_mask;
    logic [BW-1:0] d1_mem_req_burst;
    logic [1:0] d1_grant_id;

    urv_mem_arb #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .RR_EN(1)) dut (
        .clk(clk), .rstn(rstn),
        .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready), .ch_req_type(ch_req_type),
        .ch_req_addr(ch_req_addr), .ch_req_mask(ch_req_mask), .ch_req_data(ch_req_data),
        .ch_req_burst(ch_req_burst), .ch_resp_valid(ch_resp_valid), .ch_resp_ready(ch_resp_ready),
        .ch_resp_type(ch_resp_type), .ch_resp_data(ch_resp_data), .ch_resp_last(ch_resp_last),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_type(mem_req_type),
        .mem_req_addr(mem_req_addr), .mem_req_mask(mem_req_mask), .mem_req_data(mem_req_data),
        .mem_req_burst(mem_req_burst), .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_type(mem_resp_type), .mem_resp_data(mem_resp_data), .mem_resp_last(mem_resp_last),
        .busy(busy), .grant_id(grant_id)
    );

    urv_mem_arb #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .RR_EN(0)) dut_fixed (
        .clk(clk), .rstn(rstn),
        .ch_req_valid(ch_req_valid), .ch_req_ready(d1_ch_req_ready), .ch_req_type(ch_req_type),
        .ch_req_addr(ch_req_addr), .ch_req_mask(ch_req_mask), .ch_req_data(ch_req_data),
        .ch_req_burst(ch_req_burst), .ch_resp_valid(d1_ch_resp_valid), .ch_resp_ready(ch_resp_ready),
        .ch_resp_type(d1_ch_resp_type), .ch_resp_data(d1_ch_resp_data), .ch_resp_last(d1_ch_resp_last),
        .mem_req_valid(d1_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_type(d1_mem_req_type),
        .mem_req_addr(d1_mem_req_addr), .mem_req_mask(d1_mem_req_mask), .mem_req_data(d1_mem_req_data),
        .mem_req_burst(d1_mem_req_burst), .mem_resp_valid(mem_resp_valid), .mem_resp_ready(d1_mem_resp_ready),
        .mem_resp_type(mem_resp_type), .mem_resp_data(mem_resp_data), .mem_resp_last(mem_resp_last),
        .busy(d1_busy), .grant_id(d1_grant_id)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: owner channel (-1 = none), request beats still owed, response phase flag.
    int m_owner = -1, m_left = 0, m_ptr = 0, m_gid = 0;
    bit m_resp = 1'b0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_owner <= -1; m_left <= 0; m_ptr <= 0; m_gid <= 0; m_resp <= 1'b0;
        end else if (m_owner < 0) begin
            int w;
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && ch_req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) begin
                m_owner <= w;
                m_gid   <= w;
                m_resp  <= 1'b0;
                m_left  <= ch_req_type[w] ? int'(ch_req_burst[w*BW +: BW]) + 1 : 1;
            end
        end else if (!m_resp) begin
            if (ch_req_valid[m_owner] && mem_req_ready) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_resp <= 1'b1;
            end
        end else if (mem_resp_valid && ch_resp_ready[m_owner] && mem_resp_last) begin
            m_owner <= -1;
            m_resp  <= 1'b0;
            m_ptr   <= (m_owner + 1) % N;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e_crr, e_crv;
        logic e_mrv, e_mrr;
        e_crr = '0; e_crv = '0; e_mrv = 1'b0; e_mrr = 1'b0;
        if (m_owner >= 0 && !m_resp) begin
            e_mrv = ch_req_valid[m_owner];
            e_crr[m_owner] = mem_req_ready;
        end
        if (m_owner >= 0 && m_resp) begin
            e_crv[m_owner] = mem_resp_valid;
            e_mrr = ch_resp_ready[m_owner];
        end
        chk("busy", 64'(busy), 64'(m_owner >= 0));
        chk("grant_id", 64'(grant_id), 64'(m_gid));
        chk("mem_req_valid", 64'(mem_req_valid), 64'(e_mrv));
        chk("ch_req_ready", 64'(ch_req_ready), 64'(e_crr));
        chk("ch_resp_valid", 64'(ch_resp_valid), 64'(e_crv));
        chk("mem_resp_ready", 64'(mem_resp_ready), 64'(e_mrr));
        if (e_mrv) begin
            chk("mem_req_payload",
                {mem_req_type, 3'b0, mem_req_burst, mem_req_mask, mem_req_addr[19:0], mem_req_data[31:0]},
                {ch_req_type[m_owner], 3'b0, ch_req_burst[m_owner*BW +: BW], ch_req_mask[m_owner*MW +: MW],
                 ch_req_addr[m_owner*AW +: 20], ch_req_data[m_owner*DW +: DW]});
        end
        if (e_crv != '0)
            chk("resp_payload", 64'({ch_resp_type, ch_resp_last, ch_resp_data}),
                64'({mem_resp_type, mem_resp_last, mem_resp_data}));
    end

    // Observation of DUT handshakes and grants for the directed literal checks.
    int req_hs = 0, resp_hs = 0;
    logic [39:0] req_log[$];
    logic [N-1:0] resp_to[$];
    logic resp_last[$];
    logic [1:0] g0[$], g1[$];
    logic pb0 = 1'b0, pb1 = 1'b0;

    always @(negedge clk) begin
        if (rstn && mem_req_valid && mem_req_ready) begin
            req_hs <= req_hs + 1;
            req_log.push_back({mem_req_burst, mem_req_mask, mem_req_data});
        end
        if (rstn && (ch_resp_valid & ch_resp_ready) != '0) begin
            resp_hs <= resp_hs + 1;
            resp_to.push_back(ch_resp_valid);
            resp_last.push_back(ch_resp_last);
        end
        if (busy && !pb0) g0.push_back(grant_id);
        if (d1_busy && !pb1) g1.push_back(d1_grant_id);
        pb0 <= busy;
        pb1 <= d1_busy;
    end

    task automatic set_req(input int ch, input logic typ, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask, input logic [3:0] burst);
        ch_req_type[ch] = typ;
        ch_req_addr[ch*AW +: AW] = addr;
        ch_req_data[ch*DW +: DW] = data;
        ch_req_mask[ch*MW +: MW] = mask;
        ch_req_burst[ch*BW +: BW] = burst;
        ch_req_valid[ch] = 1'b1;
    endtask

    task automatic wait_req_hs(input int ch, input bit tog);
        bit hs, done;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            hs = ch_req_valid[ch] && ch_req_ready[ch];
            @(posedge clk); #1;
            if (tog) mem_req_ready = ~mem_req_ready;
            done = hs;
        end
        if (!done) chk("req_handshake_timeout", 64'(0), 64'(1));
    endtask

    task automatic send_resp(input logic [31:0] data, input logic last);
        bit hs, done;
        mem_resp_valid = 1'b1;
        mem_resp_data = data;
        mem_resp_last = last;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            hs = mem_resp_valid && mem_resp_ready;
            @(posedge clk); #1;
            done = hs;
        end
        mem_resp_valid = 1'b0;
        if (!done) chk("resp_handshake_timeout", 64'(0), 64'(1));
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        ch_req_valid = '0;
        mem_resp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    int b_req, b_resp, b_g0, b_g1;
    logic [39:0] exp_beats[3];
    logic [1:0] exp_rr[5];

    initial begin
        // Reset: requests and responses pending must not produce any handshake.
        ch_req_valid = 4'hF;
        mem_resp_valid = 1'b1;
        mem_req_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(0));
        chk("rst_ch_req_ready", 64'(ch_req_ready), 64'(0));
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        chk("rst_mem_resp_ready", 64'(mem_resp_ready), 64'(0));
        chk("rst_ch_resp_valid", 64'(ch_resp_valid), 64'(0));
        ch_req_valid = '0;
        mem_resp_valid = 1'b0;
        rstn = 1'b1;

        // Read burst 3 on ch1.
        b_req = req_hs; b_resp = resp_hs; b_g0 = g0.size();
        set_req(1, 1'b0, 32'h100, 32'h0, 4'hF, 4'd3);
        wait_req_hs(1, 1'b0);
        ch_req_valid[1] = 1'b0;
        chk("rd_grant_id", 64'(grant_id), 64'(1));
        for (int i = 0; i < 4; i++) send_resp(32'hA000 + i, i == 3);
        chk("rd_busy_after_last", 64'(busy), 64'(0));
        chk("rd_req_beats", 64'(req_hs - b_req), 64'(1));
        chk("rd_resp_beats", 64'(resp_hs - b_resp), 64'(4));
        for (int i = 0; i < 4; i++) begin
            chk("rd_resp_target", 64'(resp_to[b_resp + i]), 64'(4'b0010));
            chk("rd_resp_last", 64'(resp_last[b_resp + i]), 64'(i == 3));
        end
        chk("rd_grant_log", 64'(g0[b_g0]), 64'(1));

        // Write burst 2 on ch0, toggling mem_req_ready, response presented early.
        b_req = req_hs; b_resp = resp_hs;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_last = 1'b1; mem_resp_data = 32'h5555;
        set_req(0, 1'b1, 32'h200, 32'h1111_0000, 4'hF, 4'd2);
        wait_req_hs(0, 1'b1);
        set_req(0, 1'b1, 32'h204, 32'h2222_0001, 4'h3, 4'd7);
        wait_req_hs(0, 1'b1);
        chk("wr_no_resp_in_xfer", 64'(mem_resp_ready), 64'(0));
        set_req(0, 1'b1, 32'h208, 32'h3333_0002, 4'hC, 4'd7);
        wait_req_hs(0, 1'b1);
        ch_req_valid[0] = 1'b0;
        chk("wr_early_resp_kept", 64'(resp_hs - b_resp), 64'(0));
        chk("wr_resp_ready_in_resp", 64'(mem_resp_ready), 64'(1));
        send_resp(32'h5555, 1'b1);
        chk("wr_req_beats", 64'(req_hs - b_req), 64'(3));
        chk("wr_resp_beats", 64'(resp_hs - b_resp), 64'(1));
        exp_beats[0] = {4'd2, 4'hF, 32'h1111_0000};
        exp_beats[1] = {4'd7, 4'h3, 32'h2222_0001};
        exp_beats[2] = {4'd7, 4'hC, 32'h3333_0002};
        for (int i = 0; i < 3; i++) chk("wr_beat", 64'(req_log[b_req + i]), 64'(exp_beats[i]));
        mem_req_ready = 1'b1;

        // Response back-pressure on ch3 for 5 cycles.
        b_resp = resp_hs;
        ch_resp_ready = '0;
        set_req(3, 1'b0, 32'h300, 32'h0, 4'hF, 4'd0);
        wait_req_hs(3, 1'b0);
        ch_req_valid[3] = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF; mem_resp_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_mem_resp_ready", 64'(mem_resp_ready), 64'(0));
            chk("bp_data_held", 64'(ch_resp_data), 64'(32'hDEAD_BEEF));
            chk("bp_resp_valid", 64'(ch_resp_valid), 64'(4'b1000));
        end
        @(posedge clk); #1;
        ch_resp_ready = '1;
        send_resp(32'hDEAD_BEEF, 1'b1);
        chk("bp_delivered", 64'(resp_hs - b_resp), 64'(1));
        chk("bp_target", 64'(resp_to[b_resp]), 64'(4'b1000));

        // Fairness: all channels requesting single reads continuously.
        reset_dut();
        b_g0 = g0.size(); b_g1 = g1.size();
        for (int c = 0; c < N; c++) set_req(c, 1'b0, 32'h1000 + 32'(c), 32'h0, 4'hF, 4'd0);
        mem_resp_valid = 1'b1; mem_resp_last = 1'b1; mem_resp_data = 32'h7;
        repeat (20) @(posedge clk);
        #1;
        ch_req_valid = '0;
        mem_resp_valid = 1'b0;
        chk("rr_enough_grants", 64'(g0.size() - b_g0 >= 5), 64'(1));
        chk("fixed_enough_grants", 64'(g1.size() - b_g1 >= 5), 64'(1));
        exp_rr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", 64'(g0[b_g0 + i]), 64'(exp_rr[i]));
            chk("fixed_order", 64'(g1[b_g1 + i]), 64'(0));
        end

        // Reset asserted mid-response after 2 of 4 beats.
        reset_dut();
        b_resp = resp_hs;
        set_req(1, 1'b0, 32'h400, 32'h0, 4'hF, 4'd3);
        wait_req_hs(1, 1'b0);
        ch_req_valid[1] = 1'b0;
        send_resp(32'hB000, 1'b0);
        send_resp(32'hB001, 1'b0);
        mem_resp_valid = 1'b1; mem_resp_data = 32'hB002;
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_grant_id", 64'(grant_id), 64'(0));
        chk("mid_rst_ch_resp_valid", 64'(ch_resp_valid), 64'(0));
        chk("mid_rst_mem_resp_ready", 64'(mem_resp_ready), 64'(0));
        chk("mid_rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        chk("mid_rst_ch_req_ready", 64'(ch_req_ready), 64'(0));
        chk("mid_rst_beats_before", 64'(resp_hs - b_resp), 64'(2));
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        rstn = 1'b1;
        set_req(2, 1'b0, 32'h500, 32'h0, 4'hF, 4'd0);
        wait_req_hs(2, 1'b0);
        ch_req_valid[2] = 1'b0;
        chk("post_rst_grant", 64'(grant_id), 64'(2));
        send_resp(32'hC000, 1'b1);
        chk("post_rst_idle", 64'(busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
